modn_counter_cfg: RTL and testbench

- Parametrised successor to the fixed mod-N counter.
- Counts modulo a runtime-programmable modulus M, in either up or down direction.
- Emits a one-cycle terminal-count pulse on every wrap.
- Modulus updates arrive over a valid/ready handshake and are applied glitch-free at the next wrap boundary.
- Used as a programmable tick/rate generator feeding timers and clock-enable chains.

---
 rtl/modn_pkg.sv | 24 ++
 rtl/modn_cfg_ctrl.sv | 69 ++++++
 rtl/modn_counter_cfg.sv | 104 ++++++++++
 tb/tb_modn_counter_cfg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/modn_pkg.sv
// Shared types and helpers for the programmable mod-M counter.
// State encoding, minimum modulus and modulus legality check.
package modn_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } modn_state_t;

    localparam int unsigned MODN_MIN = 2;

    function automatic logic is_legal_mod(
        input int unsigned val,
        input int unsigned width
    );
        logic w_hi_ok;
        if (width >= 32)
            w_hi_ok = 1'b1;
        else
            w_hi_ok = (val < (32'd1 << width));
        return (val >= MODN_MIN) && w_hi_ok;
    endfunction

endpackage

// File: rtl/modn_cfg_ctrl.sv
// Modulus update control: valid/ready capture, pending hold,
// error pulse on illegal modulus, swap at wrap or clear.
module modn_cfg_ctrl
    import modn_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEF_MOD = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wrap,
    input  logic             i_clr,
    input  logic             i_cfg_valid,
    input  logic [WIDTH-1:0] i_cfg_mod,
    output logic             o_cfg_ready,
    output logic             o_cfg_err,
    output logic [WIDTH-1:0] o_mod_cur,
    output logic [WIDTH-1:0] o_mod_next,
    output logic             o_apply
);

    modn_state_t      r_state;
    logic [WIDTH-1:0] r_pend_mod;
    logic [WIDTH-1:0] r_mod_cur;
    logic             r_cfg_err;

    logic w_xfer;
    logic w_legal;
    logic w_apply;

    assign w_xfer  = i_cfg_valid && (r_state == RUN);
    assign w_legal = is_legal_mod(32'(i_cfg_mod), WIDTH);
    assign w_apply = (r_state == PEND) && (i_wrap || i_clr);

    // Modulus the datapath must use for the value it loads this edge
    assign o_mod_next  = w_apply ? r_pend_mod : r_mod_cur;
    assign o_apply     = w_apply;
    assign o_cfg_ready = (r_state == RUN);
    assign o_cfg_err   = r_cfg_err;
    assign o_mod_cur   = r_mod_cur;

    // Handshake FSM: capture legal modulus, swap it in at wrap/clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= RUN;
            r_pend_mod <= '0;
            r_mod_cur  <= WIDTH'(DEF_MOD);
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= w_xfer && !w_legal;
            unique case (r_state)
                RUN: begin
                    if (w_xfer && w_legal) begin
                        r_pend_mod <= i_cfg_mod;
                        r_state    <= PEND;
                    end
                end
                PEND: begin
                    if (w_apply) begin
                        r_mod_cur <= r_pend_mod;
                        r_state   <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

// File: rtl/modn_counter_cfg.sv
// Up/down counter modulo a runtime-programmable M with wrap pulse.
// Optional MODN_DIV_OUT_EN adds div_o, a divide-by-2M square wave.
module modn_counter_cfg
    import modn_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEF_MOD = 10
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_mod,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] mod_cur,
    output logic             y
`ifdef MODN_DIV_OUT_EN
    ,
    output logic             div_o
`endif
);

    if (!is_legal_mod(DEF_MOD, WIDTH)) begin : g_bad_def_mod
        $error("DEF_MOD outside 2..2^WIDTH-1");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_y;

    logic [WIDTH-1:0] w_mod_cur;
    logic [WIDTH-1:0] w_mod_next;
    logic             w_apply;
    logic             w_at_end;
    logic             w_wrap;

    assign w_at_end = up_dn ? (r_count >= (w_mod_cur - WIDTH'(1)))
                            : (r_count == '0);
    assign w_wrap   = en && !clr && w_at_end;

    modn_cfg_ctrl #(
        .WIDTH   (WIDTH),
        .DEF_MOD (DEF_MOD)
    ) u_ctrl (
        .i_clk       (i_clk),
        .i_rst       (reset),
        .i_wrap      (w_wrap),
        .i_clr       (clr),
        .i_cfg_valid (cfg_valid),
        .i_cfg_mod   (cfg_mod),
        .o_cfg_ready (cfg_ready),
        .o_cfg_err   (cfg_err),
        .o_mod_cur   (w_mod_cur),
        .o_mod_next  (w_mod_next),
        .o_apply     (w_apply)
    );

    // Count datapath; wrap reloads with the modulus in force next
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_y     <= 1'b0;
        end else if (clr) begin
            r_count <= up_dn ? '0 : (w_mod_next - WIDTH'(1));
            r_y     <= 1'b0;
        end else if (en) begin
            r_y <= w_wrap;
            if (up_dn)
                r_count <= w_wrap ? '0 : (r_count + WIDTH'(1));
            else
                r_count <= w_wrap ? (w_mod_next - WIDTH'(1))
                                  : (r_count - WIDTH'(1));
        end else begin
            r_y <= 1'b0;
        end
    end

`ifdef MODN_DIV_OUT_EN
    logic r_div;

    // Toggle on every wrap for a 50% duty output of period 2*M
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset)
            r_div <= 1'b0;
        else if (clr)
            r_div <= 1'b0;
        else if (w_wrap)
            r_div <= ~r_div;
    end

    assign div_o = r_div;
`endif

    assign count   = r_count;
    assign mod_cur = w_mod_cur;
    assign y       = r_y;

    logic w_unused;
    assign w_unused = w_apply;

endmodule

// File: tb/tb_modn_counter_cfg.sv
// Directed bench for modn_counter_cfg (WIDTH=8, DEF_MOD=10).
// Inputs driven 1 time unit after each rising edge, outputs checked there.
module tb_modn_counter_cfg;

    logic       i_clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       clr;
    logic       cfg_valid;
    logic [7:0] cfg_mod;
    logic       cfg_ready;
    logic       cfg_err;
    logic [7:0] count;
    logic [7:0] mod_cur;
    logic       y;
`ifdef MODN_DIV_OUT_EN
    logic       div_o;
`endif

    int checks = 0;
    int errors = 0;

    modn_counter_cfg #(
        .WIDTH   (8),
        .DEF_MOD (10)
    ) dut (
        .i_clk     (i_clk),
        .reset     (reset),
        .en        (en),
        .up_dn     (up_dn),
        .clr       (clr),
        .cfg_valid (cfg_valid),
        .cfg_mod   (cfg_mod),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .count     (count),
        .mod_cur   (mod_cur),
        .y         (y)
`ifdef MODN_DIV_OUT_EN
        ,
        .div_o     (div_o)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic step(input string tag, input int c, input logic yy);
        tick();
        chk({tag, "_cnt"}, 32'(count), c);
        chk({tag, "_y"}, 32'(y), 32'(yy));
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        up_dn     = 1'b1;
        clr       = 1'b0;
        cfg_valid = 1'b0;
        cfg_mod   = 8'd0;
        #12;
        chk("rst_cnt", 32'(count), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_mod", 32'(mod_cur), 10);
        chk("rst_rdy", 32'(cfg_ready), 1);
        chk("rst_err", 32'(cfg_err), 0);
        reset = 1'b0;
        en    = 1'b1;

        // up count, M=10: 0..9,0..9,0..4 with y on cycles 10 and 20
        for (int k = 1; k <= 25; k++)
            step("up10", k % 10, (k % 10) == 0);

        // advance from 5 to 3
        for (int k = 0; k < 8; k++) tick();
        chk("pre4_cnt", 32'(count), 3);

        // offer M=4 at count 3; old M holds until 9->0
        cfg_valid = 1'b1;
        cfg_mod   = 8'd4;
        step("hs4", 4, 1'b0);
        chk("hs4_rdy", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        for (int c = 5; c <= 9; c++) step("old10", c, 1'b0);
        chk("old10_mod", 32'(mod_cur), 10);
        step("sw4", 0, 1'b1);
        chk("sw4_mod", 32'(mod_cur), 4);
        chk("sw4_rdy", 32'(cfg_ready), 1);
        for (int k = 1; k <= 8; k++)
            step("up4", k % 4, (k % 4) == 0);

        // M=5 via clr, count down
        cfg_valid = 1'b1;
        cfg_mod   = 8'd5;
        step("hs5", 1, 1'b0);
        chk("hs5_rdy", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        up_dn     = 1'b0;
        clr       = 1'b1;
        step("clr5", 4, 1'b0);
        chk("clr5_mod", 32'(mod_cur), 5);
        chk("clr5_rdy", 32'(cfg_ready), 1);
        clr = 1'b0;
        step("dn5", 3, 1'b0);
        step("dn5", 2, 1'b0);
        step("dn5", 1, 1'b0);
        step("dn5", 0, 1'b0);
        step("dn5w", 4, 1'b1);
        step("dn5", 3, 1'b0);
        step("dn5", 2, 1'b0);
        up_dn = 1'b1;
        step("flip", 3, 1'b0);
        step("flip", 4, 1'b0);
        step("flipw", 0, 1'b1);

        // illegal moduli 1 and 0
        cfg_valid = 1'b1;
        cfg_mod   = 8'd1;
        tick();
        chk("bad1_err", 32'(cfg_err), 1);
        chk("bad1_rdy", 32'(cfg_ready), 1);
        chk("bad1_mod", 32'(mod_cur), 5);
        cfg_valid = 1'b0;
        tick();
        chk("bad1_errlo", 32'(cfg_err), 0);
        cfg_valid = 1'b1;
        cfg_mod   = 8'd0;
        tick();
        chk("bad0_err", 32'(cfg_err), 1);
        chk("bad0_rdy", 32'(cfg_ready), 1);
        chk("bad0_mod", 32'(mod_cur), 5);
        cfg_valid = 1'b0;
        tick();
        chk("bad0_errlo", 32'(cfg_err), 0);

        // clr with handshake in RUN: captured as pending only
        cfg_valid = 1'b1;
        cfg_mod   = 8'd8;
        clr       = 1'b1;
        step("clrhs", 0, 1'b0);
        chk("clrhs_mod", 32'(mod_cur), 5);
        chk("clrhs_rdy", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        clr       = 1'b0;
        for (int c = 1; c <= 4; c++) step("pend8", c, 1'b0);
        step("sw8", 0, 1'b1);
        chk("sw8_mod", 32'(mod_cur), 8);
        for (int c = 1; c <= 6; c++) step("up8", c, 1'b0);

        // en low 7 cycles at count 6, handshake still completes
        en        = 1'b0;
        cfg_valid = 1'b1;
        cfg_mod   = 8'd3;
        step("hold", 6, 1'b0);
        chk("hold_rdy", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        for (int k = 0; k < 6; k++) step("hold", 6, 1'b0);
        chk("hold_mod", 32'(mod_cur), 8);
        clr = 1'b1;
        step("clr3", 0, 1'b0);
        chk("clr3_mod", 32'(mod_cur), 3);
        chk("clr3_rdy", 32'(cfg_ready), 1);
        clr = 1'b0;

        // async reset while pending
        en        = 1'b1;
        cfg_valid = 1'b1;
        cfg_mod   = 8'd7;
        step("hs7", 1, 1'b0);
        chk("hs7_rdy", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_cnt", 32'(count), 0);
        chk("arst_mod", 32'(mod_cur), 10);
        chk("arst_rdy", 32'(cfg_ready), 1);
        chk("arst_y", 32'(y), 0);
`ifdef MODN_DIV_OUT_EN
        chk("arst_div", 32'(div_o), 0);
`endif
        #4;
        reset = 1'b0;
        for (int c = 1; c <= 9; c++) step("post", c, 1'b0);
        chk("post_mod", 32'(mod_cur), 10);

        // handshake on wrap in RUN: wrap uses old M
        cfg_valid = 1'b1;
        cfg_mod   = 8'd6;
        step("hsw", 0, 1'b1);
        chk("hsw_mod", 32'(mod_cur), 10);
        chk("hsw_rdy", 32'(cfg_ready), 0);
`ifdef MODN_DIV_OUT_EN
        chk("div_1", 32'(div_o), 1);
`endif
        cfg_valid = 1'b0;
        for (int c = 1; c <= 9; c++) step("hsw10", c, 1'b0);
        step("sw6", 0, 1'b1);
        chk("sw6_mod", 32'(mod_cur), 6);
`ifdef MODN_DIV_OUT_EN
        chk("div_0", 32'(div_o), 0);
`endif
        for (int k = 1; k <= 6; k++)
            step("up6", k % 6, (k % 6) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
